dmem_bytelane: RTL
==================

Name: dmem_bytelane

Overview:
- Parametrised successor to the pipeline data memory for the RISC-V MEM stage.
- Adds byte and halfword load/store per RV32I funct3, with sign or zero extension.
- Detects misaligned and out-of-range accesses.
- Clears memory with a sequential engine (one word per cycle) instead of a single-cycle array reset.
- Accepts requests through a ready gate and returns optionally registered responses.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two, 4..65536.
- RD_REG, 0: 0 = combinational read, response in the same cycle; 1 = response one cycle after acceptance.
- CLR_ON_RST, 1: 1 = clear all words after reset; 0 = skip clear, ready the cycle after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  access request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- ready  out  1  request accepted when req_valid && ready.
- resp_valid  out  1  response strobe, for loads and stores.
- rdata  out  32  load result, extended per funct3; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- init_done  out  1  clear sequence complete.

Behaviour:
- Reset (rst=0 at a clock edge):
  - ready=0, resp_valid=0, rdata=0, resp_err=0, init_done=0, clear index=0.
  - FSM enters CLEAR (CLR_ON_RST=1) or IDLE (CLR_ON_RST=0).
  - Array contents are not touched by reset itself.
- CLEAR:
  - Each cycle with rst=1, writes 0 to mem[index], index++.
  - After writing DEPTH-1, goes to IDLE. Exactly DEPTH cycles elapse from the first rst=1 edge to ready=1.
  - ready=0 throughout; req_valid is ignored and no response is generated.
- Reset mid-CLEAR: index restarts at 0 and the full DEPTH cycles are repeated.
- IDLE: ready=1, init_done=1; both remain 1 until the next reset.
- Addressing:
  - word = addr[log2(DEPTH)+1:2]; lane = addr[1:0].
  - Out-of-range when addr >= 4*DEPTH.
- Funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal and sets resp_err.
- Misalignment:
  - Halfword access with lane[0]=1 is misaligned.
  - Word access with lane!=0 is misaligned.
  - Byte access is never misaligned.
- Store:
  - Byte enables: SB = 1 lane; SH = lanes {0,1} or {2,3}; SW = all four.
  - wdata low bits are shifted to the lane position; only enabled bytes are written at the clock edge.
  - On error: no write, resp_err=1.
- Load:
  - Selected byte/half is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - On error: rdata=0, resp_err=1.
- Response timing:
  - RD_REG=0: resp_valid/rdata/resp_err are combinational in the accept cycle and are 0 when not accepting.
  - RD_REG=1: these outputs are registered, asserted the cycle after acceptance, and 0 otherwise.
- Ordering and hazards:
  - One access per cycle.
  - A load accepted the cycle after a store to the same word returns the new data, in both modes.
- Arithmetic: all byte shifts are lane*8 on 32-bit values; no other arithmetic on data.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - FSM state encoding ST_CLEAR/ST_IDLE.
  - Byte-enable width constant (4).
- Sub-module dmem_lane_align, purely combinational:
  - Inputs funct3, lane, wdata, raw word.
  - Outputs byte enables, shifted store data, extended load data, misaligned, illegal.
- The top level holds the array, the clear FSM/counter and the response registers.

Test Plan:
- Reset, DEPTH=16, CLR_ON_RST=1: rst low 2 cycles then high → ready=0 for exactly 16 cycles, then ready=1, init_done=1; LW at 0x3C returns 0.
- SW 0x8000_00FF at 0x10, then LB 0x10 → 0xFFFF_FFFF; LBU 0x10 → 0x0000_00FF; LH 0x12 → 0xFFFF_8000; LHU 0x12 → 0x0000_8000.
- Partial stores: SW 0x11223344 at 0x20, SB 0xAA at 0x21, SH 0xBEEF at 0x22, then LW 0x20 → 0xBEEFAA44.
- Errors:
  - SH at 0x05 → resp_err=1, memory unchanged.
  - LW at 0x06 → resp_err=1, rdata=0.
  - Load with funct3=011 → resp_err=1.
  - LW at 4*DEPTH → resp_err=1.
- Reset mid-clear: drop rst at clear cycle 7, release → ready rises exactly DEPTH cycles after release; no request is accepted while ready=0.
- RD_REG=1: LW accepted in cycle n → resp_valid and rdata in cycle n+1 only; SW then LW to the same address back-to-back → new data returned.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the byte-lane data memory: funct3 codes, FSM states, lane count.
// No logic; imported by dmem_lane_align and dmem_bytelane.
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for RV32I loads/stores: byte enables, store shift, load extract/extend, error decode.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies every output with its own accept.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [31:0]     wdata,
  input  logic [31:0]     raw,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdat_sh,
  output logic [31:0]     ldata,
  output logic            misal,
  output logic            illegal
);
  logic [4:0]  sh;
  logic [31:0] rsh;

  always_comb begin
    sh      = {lane, 3'b000};
    wdat_sh = wdata << sh;
    rsh     = raw >> sh;
    be      = '0;
    ldata   = '0;
    misal   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << lane;
        ldata = {{24{rsh[7]}}, rsh[7:0]};
      end
      F3_BU: begin
        ldata   = {24'd0, rsh[7:0]};
        illegal = we;
      end
      F3_H: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        ldata = {{16{rsh[15]}}, rsh[15:0]};
        misal = lane[0];
      end
      F3_HU: begin
        ldata   = {16'd0, rsh[15:0]};
        misal   = lane[0];
        illegal = we;
      end
      F3_W: begin
        be    = 4'b1111;
        ldata = raw;
        misal = (lane != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/dmem_bytelane.sv
// RV32I data memory with byte/half/word access, error detection and a one-word-per-cycle clear engine.
// Latency: response in the accept cycle (RD_REG=0) or one cycle later (RD_REG=1).
// Backpressure: ready is low only while clearing after reset; afterwards every request is accepted.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int RD_REG     = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic        init_done
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]     mem [DEPTH];
  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx;
  logic            rdy_q;

  logic [AW-1:0]   word;
  logic [1:0]      lane;
  logic            oor, acc, err, misal, illegal;
  logic [BE_W-1:0] be;
  logic [31:0]     raw, wdat_sh, ldata;
  logic            c_vld, c_err;
  logic [31:0]     c_rdata;

  assign word  = addr[AW+1:2];
  assign lane  = addr[1:0];
  assign oor   = (addr >> (AW + 2)) != 32'd0;
  assign raw   = mem[word];
  assign acc   = req_valid && rdy_q;
  assign err   = oor || misal || illegal;
  assign ready     = rdy_q;
  assign init_done = rdy_q;

  dmem_lane_align u_align (
    .we      (req_we),
    .funct3  (req_funct3),
    .lane    (lane),
    .wdata   (wdata),
    .raw     (raw),
    .be      (be),
    .wdat_sh (wdat_sh),
    .ldata   (ldata),
    .misal   (misal),
    .illegal (illegal)
  );

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_idx == AW'(DEPTH - 1))
      state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      clr_idx <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == ST_IDLE);
      if (state == ST_CLEAR)
        clr_idx <= clr_idx + AW'(1);
    end
  end

  // Array has no reset; rst only gates the clear and store write enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (acc && req_we && !err) begin
        for (int i = 0; i < BE_W; i++)
          if (be[i]) mem[word][8*i +: 8] <= wdat_sh[8*i +: 8];
      end
    end
  end

  assign c_vld   = acc;
  assign c_err   = acc && err;
  assign c_rdata = (acc && !req_we && !err) ? ldata : 32'd0;

  generate
    if (RD_REG != 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst) begin
          resp_valid <= 1'b0;
          rdata      <= '0;
          resp_err   <= 1'b0;
        end else begin
          resp_valid <= c_vld;
          rdata      <= c_rdata;
          resp_err   <= c_err;
        end
      end
    end else begin : g_comb
      assign resp_valid = c_vld;
      assign rdata      = c_rdata;
      assign resp_err   = c_err;
    end
  endgenerate
endmodule
